// File: rtl/tug_pkg.sv
// Shared types and helpers for the tug-of-war match scorer.
package tug_pkg;

    // Match phase: playing a game, game decided, match decided.
    typedef enum logic [1:0] {
        PH_PLAY  = 2'd0,
        PH_WON   = 2'd1,
        PH_MATCH = 2'd2
    } phase_t;

    // Signed width needed to hold -(half+1)..+(half+1).
    function automatic int pos_width(input int half);
        return $clog2(half + 2) + 1;
    endfunction

    // One bit of the track display for a marker position.
    // Bit half is the centre; left positions sit above it, right positions below.
    // A win position lights the whole winning half.
    function automatic logic score_bit(input int half, input int pos, input int idx);
        if (pos <= -(half + 1)) begin
            return (idx >= half + 1);
        end else if (pos >= half + 1) begin
            return (idx <= half - 1);
        end else begin
            return (idx == half - pos);
        end
    endfunction

endpackage

// File: rtl/tug_step_calc.sv
// Combinational next marker position for one decided round.
module tug_step_calc #(
    parameter int HALF    = 3,
    parameter int CATCHUP = 2,
    parameter int POS_W   = 4
) (
    input  logic signed [POS_W-1:0] i_pos,
    input  logic                    i_mr,
    input  logic                    i_leds_on,
    output logic signed [POS_W-1:0] o_next_pos
);

    localparam logic signed [POS_W-1:0] C_EDGE = POS_W'(HALF);
    localparam logic signed [POS_W-1:0] C_CU   = POS_W'(CATCHUP);
    localparam logic signed [POS_W-1:0] C_ONE  = POS_W'(1);

    // Single step toward the round winner; a proper point by the player
    // pinned at the last position before defeat pulls back CATCHUP steps.
    always_comb begin
        o_next_pos = i_mr ? (i_pos + C_ONE) : (i_pos - C_ONE);
        if (i_leds_on && i_mr && (i_pos == -C_EDGE)) begin
            o_next_pos = i_pos + C_CU;
        end else if (i_leds_on && !i_mr && (i_pos == C_EDGE)) begin
            o_next_pos = i_pos - C_CU;
        end
    end

endmodule

// File: rtl/tug_match_scorer.sv
// Tug-of-war match scorer: marker position, per-side game counts, match decision.
//
// phase    | meaning
// PH_PLAY  | game in progress, rounds move the marker
// PH_WON   | game decided, marker frozen until new_game
// PH_MATCH | match decided, new_game clears the game counts
module tug_match_scorer
    import tug_pkg::*;
#(
    parameter int HALF         = 3,
    parameter int CATCHUP      = 2,
    parameter int GAMES_TO_WIN = 2
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              winrnd,
    input  logic              right,
    input  logic              leds_on,
    input  logic              tie,
    input  logic              new_game,
    output logic [2*HALF:0]   score,
    output logic [2:0]        games_l,
    output logic [2:0]        games_r,
    output logic              game_over,
    output logic              match_over,
    output logic              err
);

    localparam int POS_W = pos_width(HALF);
    localparam logic signed [POS_W-1:0] C_WIN  = POS_W'(HALF + 1);
    localparam logic signed [POS_W-1:0] C_ZERO = '0;
    localparam logic [2:0]              C_GTW  = 3'(GAMES_TO_WIN);

    phase_t                  r_phase;
    logic signed [POS_W-1:0] r_pos;
    logic [2:0]              r_games_l;
    logic [2:0]              r_games_r;
    logic                    r_err;

    phase_t                  w_phase_nxt;
    logic signed [POS_W-1:0] w_pos_nxt;
    logic [2:0]              w_games_l_nxt;
    logic [2:0]              w_games_r_nxt;
    logic                    w_err_nxt;
    logic signed [POS_W-1:0] w_step_pos;
    logic                    w_mr;
    logic                    w_illegal;

    assign w_mr = ~(right ^ leds_on);

    tug_step_calc #(
        .HALF    (HALF),
        .CATCHUP (CATCHUP),
        .POS_W   (POS_W)
    ) u_step (
        .i_pos      (r_pos),
        .i_mr       (w_mr),
        .i_leds_on  (leds_on),
        .o_next_pos (w_step_pos)
    );

    // Position must be on the track and consistent with the phase.
    always_comb begin
        w_illegal = 1'b0;
        if ((r_pos > C_WIN) || (r_pos < -C_WIN)) begin
            w_illegal = 1'b1;
        end
        case (r_phase)
            PH_PLAY: begin
                if ((r_pos == C_WIN) || (r_pos == -C_WIN)) begin
                    w_illegal = 1'b1;
                end
            end
            PH_WON, PH_MATCH: begin
                if ((r_pos != C_WIN) && (r_pos != -C_WIN)) begin
                    w_illegal = 1'b1;
                end
            end
            default: w_illegal = 1'b1;
        endcase
    end

    // Next phase, position and game counts.
    always_comb begin
        w_phase_nxt   = r_phase;
        w_pos_nxt     = r_pos;
        w_games_l_nxt = r_games_l;
        w_games_r_nxt = r_games_r;
        w_err_nxt     = r_err;
        if (w_illegal) begin
            w_phase_nxt = PH_PLAY;
            w_pos_nxt   = C_ZERO;
            w_err_nxt   = 1'b1;
        end else begin
            case (r_phase)
                PH_PLAY: begin
                    if (winrnd && !tie) begin
                        w_pos_nxt = w_step_pos;
                        if (w_step_pos == -C_WIN) begin
                            w_games_l_nxt = r_games_l + 3'd1;
                            w_phase_nxt   = (w_games_l_nxt == C_GTW) ? PH_MATCH : PH_WON;
                        end else if (w_step_pos == C_WIN) begin
                            w_games_r_nxt = r_games_r + 3'd1;
                            w_phase_nxt   = (w_games_r_nxt == C_GTW) ? PH_MATCH : PH_WON;
                        end
                    end
                end
                PH_WON: begin
                    if (new_game) begin
                        w_phase_nxt = PH_PLAY;
                        w_pos_nxt   = C_ZERO;
                    end
                end
                PH_MATCH: begin
                    if (new_game) begin
                        w_phase_nxt   = PH_PLAY;
                        w_pos_nxt     = C_ZERO;
                        w_games_l_nxt = 3'd0;
                        w_games_r_nxt = 3'd0;
                    end
                end
                default: begin
                    w_phase_nxt = PH_PLAY;
                end
            endcase
        end
    end

    // State registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_phase   <= PH_PLAY;
            r_pos     <= C_ZERO;
            r_games_l <= 3'd0;
            r_games_r <= 3'd0;
            r_err     <= 1'b0;
        end else begin
            r_phase   <= w_phase_nxt;
            r_pos     <= w_pos_nxt;
            r_games_l <= w_games_l_nxt;
            r_games_r <= w_games_r_nxt;
            r_err     <= w_err_nxt;
        end
    end

    for (genvar i = 0; i <= 2*HALF; i++) begin : g_score
        assign score[i] = score_bit(HALF, int'(r_pos), i);
    end

    assign games_l    = r_games_l;
    assign games_r    = r_games_r;
    assign game_over  = (r_phase == PH_WON) || (r_phase == PH_MATCH);
    assign match_over = (r_phase == PH_MATCH);
    assign err        = r_err;

endmodule
